// File: rtl/fifo_arb_pkg.sv
// Shared defaults, the arbiter state encoding and a pointer-width helper
// for the FIFO write-port arbiter.
package fifo_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_FIFO_WIDTH = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        ERR   = 2'd2
    } arb_state_e;

    // Width of an index into NUM_REQ requesters; never narrower than one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: one-hot grant for the first request at or after ptr,
// wrapping from NUM_REQ-1 back to 0. Purely combinational.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = ptr_w(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    // Scan upward from ptr with wrap and keep only the first hit.
    always_comb begin
        int   idx;
        logic found;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[PTR_W'(idx)]) begin
                gnt[PTR_W'(idx)] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Arbitrates NUM_REQ requesters onto a single FIFO write port. Grants are
// round-robin, writes are registered, and the FIFO's write acknowledge is
// routed back to the requester whose word it confirms. Overflow is latched
// as a sticky error that blocks grants until cleared.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ-1:0][FIFO_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]                  gnt,
    output logic [NUM_REQ-1:0]                  ack,
    output logic                                fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]               fifo_data_in,
    input  logic                                fifo_full,
    input  logic                                fifo_almostfull,
    input  logic                                fifo_wr_ack,
    input  logic                                fifo_overflow,
    input  logic                                err_clr,
    output logic                                err
);

    localparam int PTR_W = ptr_w(NUM_REQ);

    arb_state_e             state_q, state_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [FIFO_WIDTH-1:0]  data_q, data_d;
    logic                   wr_en_q;
    logic                   err_q, err_d;
    logic [PTR_W-1:0]       gnt_idx;
    logic [PTR_W-1:0]       idx_p1_q;
    logic [PTR_W-1:0]       idx_p2_q;
    logic                   vld_p2_q;
    logic [NUM_REQ-1:0]     pick;
    logic                   stall_cond;
    logic                   issue;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req (req),
        .ptr (rr_ptr_q),
        .gnt (pick)
    );

    // A write already registered while almost full would fill the last slot,
    // so that case stalls just like a full FIFO.
    assign stall_cond = fifo_full | (fifo_almostfull & wr_en_q);
    assign issue      = (state_q == RUN) & ~stall_cond & ~rst;
    assign gnt        = issue ? pick : '0;

    assign fifo_wr_en   = wr_en_q;
    assign fifo_data_in = data_q;
    assign err          = err_q;

    // Encode the granted index; advance the pointer past it and capture its data.
    always_comb begin
        gnt_idx  = '0;
        rr_ptr_d = rr_ptr_q;
        data_d   = data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = PTR_W'(i);
            end
        end
        if (|gnt) begin
            rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
            data_d   = req_data[gnt_idx];
        end
    end

    // Next state and sticky error; overflow overrides everything, including err_clr.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            RUN:     if (stall_cond) state_d = STALL;
            STALL:   if (!fifo_full && !fifo_almostfull) state_d = RUN;
            ERR:     if (err_clr) state_d = RUN;
            default: state_d = RUN;
        endcase
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (fifo_overflow) begin
            state_d = ERR;
            err_d   = 1'b1;
        end
    end

    // Acknowledge the requester whose write the FIFO confirms, unless that write overflowed.
    always_comb begin
        ack = '0;
        if (vld_p2_q && fifo_wr_ack && !fifo_overflow && !rst) begin
            ack[idx_p2_q] = 1'b1;
        end
    end

    // State, pointer, write register and the in-flight index pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            rr_ptr_q <= '0;
            wr_en_q  <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
            idx_p1_q <= '0;
            idx_p2_q <= '0;
            vld_p2_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
            // grant -> write cycle
            wr_en_q  <= |gnt;
            data_q   <= data_d;
            idx_p1_q <= gnt_idx;
            // write cycle -> acknowledge cycle
            vld_p2_q <= wr_en_q;
            idx_p2_q <= idx_p1_q;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb. Stimulus checks grants and pushes the
// expected write words and acks into queues; a monitor pops and compares them
// whenever the DUT writes or acknowledges. A small FIFO model (depth 8)
// produces fill-level flags and write acknowledges.
module tb_fifo_wr_arb;

    localparam int NREQ  = 4;
    localparam int W     = 16;
    localparam int DEPTH = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ-1:0][W-1:0] req_data = '0;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic                  fifo_wr_en;
    logic [W-1:0]          fifo_data_in;
    logic                  fifo_full;
    logic                  fifo_almostfull;
    logic                  fifo_wr_ack = 1'b0;
    logic                  fifo_overflow = 1'b0;
    logic                  err_clr = 1'b0;
    logic                  err;

    logic                  force_full = 1'b0;
    logic                  force_af   = 1'b0;
    logic                  clr_fifo   = 1'b0;
    int                    cnt = 0;
    logic                  wr_seen = 1'b0;
    logic                  clr_seen = 1'b0;

    logic [W-1:0]          dat [NREQ];
    logic [W-1:0]          exp_data_q [$];
    logic [NREQ-1:0]       exp_ack_q  [$];

    int vectors     = 0;
    int miscompares = 0;

    fifo_wr_arb #(.NUM_REQ(NREQ), .FIFO_WIDTH(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .req_data        (req_data),
        .gnt             (gnt),
        .ack             (ack),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_data_in    (fifo_data_in),
        .fifo_full       (fifo_full),
        .fifo_almostfull (fifo_almostfull),
        .fifo_wr_ack     (fifo_wr_ack),
        .fifo_overflow   (fifo_overflow),
        .err_clr         (err_clr),
        .err             (err)
    );

    always #5 clk = ~clk;

    // FIFO model: counts writes, acknowledges each write one cycle later.
    assign fifo_full       = force_full | (cnt >= DEPTH);
    assign fifo_almostfull = force_af   | (cnt >= DEPTH - 1);

    always @(negedge clk) begin
        wr_seen  = (fifo_wr_en === 1'b1);
        clr_seen = clr_fifo;
    end

    always @(posedge clk) begin
        #1;
        fifo_wr_ack = wr_seen;
        if (clr_seen) cnt = 0;
        else if (wr_seen) cnt = cnt + 1;
    end

    // Monitor: every write and every ack must match the next expectation.
    always @(negedge clk) begin
        logic [W-1:0]    ed;
        logic [NREQ-1:0] ea;
        if (fifo_wr_en === 1'b1) begin
            vectors++;
            if (exp_data_q.size() == 0) begin
                miscompares++;
                $display("FAIL wr_data: got unexpected write %h, required no write", fifo_data_in);
            end else begin
                ed = exp_data_q.pop_front();
                if (fifo_data_in !== ed) begin
                    miscompares++;
                    $display("FAIL wr_data: got %h, required %h", fifo_data_in, ed);
                end
            end
        end
        if (ack !== '0) begin
            vectors++;
            if (exp_ack_q.size() == 0) begin
                miscompares++;
                $display("FAIL ack: got unexpected %b, required 0000", ack);
            end else begin
                ea = exp_ack_q.pop_front();
                if (ack !== ea) begin
                    miscompares++;
                    $display("FAIL ack: got %b, required %b", ack, ea);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] data_of(input logic [NREQ-1:0] oh);
        logic [W-1:0] d;
        d = '0;
        for (int i = 0; i < NREQ; i++) if (oh[i]) d = dat[i];
        return d;
    endfunction

    task automatic set_data(input logic [W-1:0] base);
        for (int i = 0; i < NREQ; i++) begin
            dat[i]      = base + 16'h0111 * 16'(i);
            req_data[i] = dat[i];
        end
    endtask

    // One clock cycle: drive req, check gnt mid-cycle, queue the expected write/ack.
    task automatic cyc(input logic [NREQ-1:0] r, input logic [NREQ-1:0] eg, input bit exp_ack);
        req = r;
        @(negedge clk);
        chk("gnt", 32'(gnt), 32'(eg));
        if (eg != '0) begin
            exp_data_q.push_back(data_of(eg));
            if (exp_ack) exp_ack_q.push_back(eg);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        clr_fifo = 1'b1;
        cyc(4'b1111, 4'b0000, 1'b0);
        cyc(4'b1111, 4'b0000, 1'b0);
        rst      = 1'b0;
        clr_fifo = 1'b0;
        req      = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_data(16'h1A00);
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_data",  32'(fifo_data_in), 0);
        chk("rst_err",   32'(err), 0);
        chk("rst_ack",   32'(ack), 0);

        // Two requesters, pointer at 0: 0 then 2, data and acks follow.
        cyc(4'b0101, 4'b0001, 1'b1);
        cyc(4'b0100, 4'b0100, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b0);
        chk("data_hold",  32'(fifo_data_in), 32'(dat[2]));
        chk("idle_wr_en", 32'(fifo_wr_en), 0);

        // Full blocks grants; almostfull alone keeps STALL; resume at pointer 3.
        force_full = 1'b1;
        cyc(4'b1111, 4'b0000, 1'b0);
        chk("full_wr_en", 32'(fifo_wr_en), 0);
        cyc(4'b1111, 4'b0000, 1'b0);
        force_full = 1'b0;
        force_af   = 1'b1;
        cyc(4'b1111, 4'b0000, 1'b0);
        force_af   = 1'b0;
        cyc(4'b1111, 4'b0000, 1'b0);
        cyc(4'b1111, 4'b1000, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b0);

        // Overflow: ack for the overflowing write suppressed, sticky err, no grants.
        cyc(4'b0010, 4'b0010, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);
        fifo_overflow = 1'b1;
        cyc(4'b0000, 4'b0000, 1'b0);
        fifo_overflow = 1'b0;
        chk("err_set", 32'(err), 1);
        cyc(4'b1111, 4'b0000, 1'b0);
        cyc(4'b1111, 4'b0000, 1'b0);
        err_clr       = 1'b1;
        fifo_overflow = 1'b1;
        cyc(4'b1111, 4'b0000, 1'b0);
        fifo_overflow = 1'b0;
        chk("err_ovf_wins", 32'(err), 1);
        cyc(4'b1111, 4'b0000, 1'b0);
        err_clr = 1'b0;
        chk("err_cleared", 32'(err), 0);
        cyc(4'b1111, 4'b0100, 1'b1);
        cyc(4'b1111, 4'b1000, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);

        // All requesters into an empty depth-8 FIFO: 8 grants then stall.
        set_data(16'hC050);
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cyc(4'b1111, 4'(1 << (k % 4)), 1'b1);
        end
        cyc(4'b1111, 4'b0000, 1'b0);
        clr_fifo = 1'b1;
        cyc(4'b1111, 4'b0000, 1'b0);
        clr_fifo = 1'b0;
        cyc(4'b1111, 4'b0000, 1'b0);
        cyc(4'b1111, 4'b0001, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);

        // Reset with a write in flight: outputs clear, late FIFO ack ignored.
        set_data(16'h7E10);
        do_reset();
        cyc(4'b0001, 4'b0001, 1'b0);
        rst = 1'b1;
        cyc(4'b1111, 4'b0000, 1'b0);
        rst = 1'b0;
        req = '0;
        chk("rst_mid_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_mid_data",  32'(fifo_data_in), 0);
        @(negedge clk);
        chk("rst_mid_ack", 32'(ack), 0);
        @(posedge clk);
        #1;
        cyc(4'b0010, 4'b0010, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);

        chk("data_q_drained", 32'(exp_data_q.size()), 0);
        chk("ack_q_drained",  32'(exp_ack_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the FIFO write port.
REQ-002 SHALL have parameter FIFO_WIDTH, default 16, width of the FIFO data word.
REQ-003 SHALL be one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester write request, held until granted.
REQ-007 SHALL have port req_data  input  NUM_REQ x FIFO_WIDTH  per-requester data, stable while req is high.
REQ-008 SHALL have port gnt  output  NUM_REQ  one-hot grant; combinational from req and registered state.
REQ-009 SHALL have port ack  output  NUM_REQ  one-cycle pulse when the FIFO confirms the granted write.
REQ-010 SHALL have port fifo_wr_en  output  1  registered FIFO write enable.
REQ-011 SHALL have port fifo_data_in  output  FIFO_WIDTH  registered FIFO write data.
REQ-012 SHALL have ports fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow  input  1 each  FIFO status.
REQ-013 SHALL have port err_clr  input  1  clears the sticky error.
REQ-014 SHALL have port err  output  1  sticky overflow error flag.

Function
REQ-015 SHALL implement an FSM with states RUN, STALL and ERR.
REQ-016 Issue condition SHALL be: state==RUN, fifo_full==0, and NOT (fifo_almostfull==1 AND fifo_wr_en==1).
REQ-017 When the issue condition holds and any req is high, the block SHALL assert gnt for exactly one requester: the first set bit at or after rr_ptr, wrapping from NUM_REQ-1 to 0.
REQ-018 On a grant to index i, the block SHALL load rr_ptr with (i+1) mod NUM_REQ; otherwise rr_ptr SHALL hold.
REQ-019 On a grant to index i at edge T, fifo_data_in SHALL load req_data[i] and fifo_wr_en SHALL be 1 in cycle T+1; otherwise fifo_wr_en SHALL be 0 and fifo_data_in SHALL hold.
REQ-020 The block SHALL record the granted index per issued write, and when fifo_wr_ack is 1 in cycle T+2 it SHALL pulse ack[i] in that same cycle.
REQ-021 The requester SHALL drop or refresh req the cycle after gnt; a still-high req SHALL be treated as a new request.
REQ-022 RUN -> STALL SHALL occur when fifo_full==1, or when fifo_almostfull==1 with fifo_wr_en==1.
REQ-023 STALL -> RUN SHALL occur when fifo_full==0 and fifo_almostfull==0; no gnt SHALL be asserted in STALL.
REQ-024 Any state -> ERR SHALL occur when fifo_overflow==1; the block SHALL set err and suppress ack for that write.
REQ-025 ERR -> RUN SHALL occur only on err_clr==1; err_clr SHALL clear err; no gnt SHALL be asserted in ERR.
REQ-026 Simultaneous fifo_overflow and err_clr SHALL resolve to ERR with err=1 (overflow wins).
REQ-027 gnt SHALL be all-zero when req is all-zero.

Reset
REQ-028 When rst==1 at a clock edge, the block SHALL set state=RUN, rr_ptr=0, fifo_wr_en=0, fifo_data_in=0, ack=0, err=0, and clear the in-flight index.
REQ-029 gnt SHALL be 0 in any cycle where rst==1.
REQ-030 A write in flight at reset SHALL NOT produce an ack after reset.

Structure
REQ-031 Package fifo_arb_pkg SHALL hold the FIFO_WIDTH and NUM_REQ defaults and the state enum typedef (RUN, STALL, ERR).
REQ-032 The round-robin picker SHALL be a sub-module rr_pick (inputs req and ptr; output one-hot gnt), purely combinational.

Verification
REQ-033 req=4'b0101, rr_ptr=0, FIFO empty -> gnt 0001, then 0100 on consecutive cycles; fifo_data_in follows with 1-cycle lag; ack[0] and ack[2] follow with 2-cycle lag.
REQ-034 All four req held high for 8 cycles, FIFO_DEPTH 8 -> grants 0,1,2,3,0,1,2,3 until almostfull; state goes to STALL; no fifo_overflow.
REQ-035 fifo_full=1 with req=4'b1111 -> gnt=0, fifo_wr_en=0; release full and almostfull -> RUN and grant resumes at the saved rr_ptr.
REQ-036 Force fifo_overflow=1 for 1 cycle -> err=1, state ERR, no gnt; err_clr pulse -> err=0, RUN next cycle.
REQ-037 Assert rst while fifo_wr_en=1 -> next cycle all outputs 0, rr_ptr=0, and no ack pulse even if fifo_wr_ack arrives.
